// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared constants, FSM state type and address helper for sram_controller
package sram_pkg;

  localparam int DEFAULT_ROW_WORDS = 4096;

  localparam logic [12:0] REGION_ROWCACHE = 13'd0;
  localparam logic [12:0] REGION_OUTPUT   = 13'd1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_MEM = 2'd1,
    RD_OUT = 2'd2
  } state_t;

  // An address is outside the storage when its region is beyond the output
  // array or its column is past the last word of a bank.
  function automatic logic addr_oob(input logic [25:0] addr, input int words);
    return (addr[25:13] > REGION_OUTPUT) || (int'({19'd0, addr[12:0]}) >= words);
  endfunction

endpackage

// File: rtl/sram_bank.sv
// rtl/sram_bank.sv - single-port synchronous RAM bank, 32-bit words
module sram_bank #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Contents are deliberately left uninitialised; the read port returns the old word on a same-cycle write
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - two-bank SRAM controller: single-cycle writes, three-cycle reads, sticky error flags
module sram_controller
  import sram_pkg::*;
#(
  parameter int ROW_WORDS = DEFAULT_ROW_WORDS
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        sram_en,
  input  logic        mode_sram,
  input  logic        addrCalc_mode_sram,
  input  logic [25:0] address_sram,
  input  logic [31:0] sram_dataFromSDRAM,
  input  logic [31:0] postFilterData,
  input  logic        clear_err,
  output logic [31:0] data_sram,
  output logic        sram_datareadvalid,
  output logic        oob_err,
  output logic        ovr_err
);

  localparam int AW = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;

  state_t        state;
  state_t        state_next;
  logic          wr_req;
  logic          rd_req;
  logic          busy_hit;
  logic          req_oob;
  logic [AW-1:0] rd_col;
  logic          rd_out_bank;
  logic          rd_oob;
  logic [31:0]   data_hold;
  logic [31:0]   wdata;
  logic [AW-1:0] bank_addr;
  logic          we_rc;
  logic          we_out;
  logic [31:0]   rdata_rc;
  logic [31:0]   rdata_out;
  logic [31:0]   rd_word;

  assign req_oob = addr_oob(address_sram, ROW_WORDS);
  assign wdata   = addrCalc_mode_sram ? postFilterData : sram_dataFromSDRAM;

  // Writes are dropped when out of range; each bank only sees writes to its own region
  assign we_rc  = wr_req && !req_oob && (address_sram[25:13] == REGION_ROWCACHE);
  assign we_out = wr_req && !req_oob && (address_sram[25:13] == REGION_OUTPUT);

  // While idle the bank follows the request column; during a read it holds the captured column
  assign bank_addr = (state == IDLE) ? address_sram[AW-1:0] : rd_col;

  // Out-of-range reads still take the full read path but deliver zero
  assign rd_word = rd_oob ? 32'h0 : (rd_out_bank ? rdata_out : rdata_rc);

  // During the read-out cycle the fresh word is shown directly; otherwise the last one is held
  assign data_sram          = (state == RD_OUT) ? rd_word : data_hold;
  assign sram_datareadvalid = (state == RD_OUT);

  // Next-state and request decode; any strobe outside IDLE is an overrun and is discarded
  always_comb begin
    state_next = state;
    wr_req     = 1'b0;
    rd_req     = 1'b0;
    busy_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (sram_en) begin
          if (mode_sram) begin
            wr_req = 1'b1;
          end else begin
            rd_req     = 1'b1;
            state_next = RD_MEM;
          end
        end
      end
      RD_MEM: begin
        busy_hit   = sram_en;
        state_next = RD_OUT;
      end
      RD_OUT: begin
        busy_hit   = sram_en;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset aborts any read in flight
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the read target when a read is accepted
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_col      <= '0;
      rd_out_bank <= 1'b0;
      rd_oob      <= 1'b0;
    end else if (rd_req) begin
      rd_col      <= address_sram[AW-1:0];
      rd_out_bank <= (address_sram[25:13] == REGION_OUTPUT);
      rd_oob      <= req_oob;
    end
  end

  // Keep the delivered word so data_sram is stable between reads
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_hold <= 32'h0;
    end else if (state == RD_OUT) begin
      data_hold <= rd_word;
    end
  end

  // Sticky error flags; a new error event outranks a clear in the same cycle
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      oob_err <= 1'b0;
      ovr_err <= 1'b0;
    end else begin
      if ((wr_req || rd_req) && req_oob) begin
        oob_err <= 1'b1;
      end else if (clear_err) begin
        oob_err <= 1'b0;
      end
      if (busy_hit) begin
        ovr_err <= 1'b1;
      end else if (clear_err) begin
        ovr_err <= 1'b0;
      end
    end
  end

  sram_bank #(
    .DEPTH (ROW_WORDS),
    .AW    (AW)
  ) u_rowcache (
    .clk   (clk),
    .we    (we_rc),
    .addr  (bank_addr),
    .wdata (wdata),
    .rdata (rdata_rc)
  );

  sram_bank #(
    .DEPTH (ROW_WORDS),
    .AW    (AW)
  ) u_output (
    .clk   (clk),
    .we    (we_out),
    .addr  (bank_addr),
    .wdata (wdata),
    .rdata (rdata_out)
  );

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - self-checking bench for sram_controller against a behavioural model
module tb_sram_controller;

  localparam int ROW_WORDS = 4096;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        sram_en = 1'b0;
  logic        mode_sram = 1'b0;
  logic        addrCalc_mode_sram = 1'b0;
  logic [25:0] address_sram = '0;
  logic [31:0] sram_dataFromSDRAM = '0;
  logic [31:0] postFilterData = '0;
  logic        clear_err = 1'b0;
  logic [31:0] data_sram;
  logic        sram_datareadvalid;
  logic        oob_err;
  logic        ovr_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_controller #(.ROW_WORDS(ROW_WORDS)) dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .sram_en            (sram_en),
    .mode_sram          (mode_sram),
    .addrCalc_mode_sram (addrCalc_mode_sram),
    .address_sram       (address_sram),
    .sram_dataFromSDRAM (sram_dataFromSDRAM),
    .postFilterData     (postFilterData),
    .clear_err          (clear_err),
    .data_sram          (data_sram),
    .sram_datareadvalid (sram_datareadvalid),
    .oob_err            (oob_err),
    .ovr_err            (ovr_err)
  );

  // Model: storage as a sparse map keyed by the full address, plus a count of busy edges.
  logic [31:0] model_mem [int];
  int          busy = 0;
  logic [31:0] pend_data = '0;
  logic        exp_valid = 1'b0;
  logic [31:0] exp_data = '0;
  logic        exp_oob = 1'b0;
  logic        exp_ovr = 1'b0;

  function automatic bit is_oob(input logic [25:0] a);
    return (a[25:13] > 13'd1) || (int'({19'd0, a[12:0]}) >= ROW_WORDS);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // A read accepted at an edge occupies the next two edges; valid is seen after the first of them.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      busy      = 0;
      exp_valid = 1'b0;
      exp_data  = '0;
      exp_oob   = 1'b0;
      exp_ovr   = 1'b0;
    end else begin
      bit set_oob;
      bit set_ovr;
      set_oob   = 1'b0;
      set_ovr   = 1'b0;
      exp_valid = (busy == 2);
      if (exp_valid) exp_data = pend_data;
      if (busy > 0) begin
        busy--;
        if (sram_en) set_ovr = 1'b1;
      end else if (sram_en) begin
        set_oob = is_oob(address_sram);
        if (mode_sram) begin
          if (!set_oob)
            model_mem[int'(address_sram)] = addrCalc_mode_sram ? postFilterData : sram_dataFromSDRAM;
        end else begin
          busy      = 2;
          pend_data = set_oob ? 32'h0 : model_mem[int'(address_sram)];
        end
      end
      if (set_oob) exp_oob = 1'b1;
      else if (clear_err) exp_oob = 1'b0;
      if (set_ovr) exp_ovr = 1'b1;
      else if (clear_err) exp_ovr = 1'b0;
    end
  end

  // Compare every cycle on the falling edge
  always @(negedge clk) begin
    check("model_valid", {31'd0, sram_datareadvalid}, {31'd0, exp_valid});
    check("model_data", data_sram, exp_data);
    check("model_oob", {31'd0, oob_err}, {31'd0, exp_oob});
    check("model_ovr", {31'd0, ovr_err}, {31'd0, exp_ovr});
  end

  task automatic cyc(input logic en, input logic wr, input logic sel, input logic [12:0] region,
                     input logic [12:0] col, input logic [31:0] sd, input logic [31:0] pf,
                     input logic clr);
    sram_en            = en;
    mode_sram          = wr;
    addrCalc_mode_sram = sel;
    address_sram       = {region, col};
    sram_dataFromSDRAM = sd;
    postFilterData     = pf;
    clear_err          = clr;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 13'd0, 13'd0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic wr_word(input logic [12:0] region, input logic [12:0] col, input logic sel,
                         input logic [31:0] data);
    if (sel) cyc(1'b1, 1'b1, 1'b1, region, col, ~data, data, 1'b0);
    else     cyc(1'b1, 1'b1, 1'b0, region, col, data, ~data, 1'b0);
  endtask

  task automatic rd_expect(input string name, input logic [12:0] region, input logic [12:0] col,
                           input logic [31:0] exp);
    cyc(1'b1, 1'b0, 1'b0, region, col, 32'h0, 32'h0, 1'b0);
    idle(1);
    check({name, "_valid"}, {31'd0, sram_datareadvalid}, 32'd1);
    check({name, "_data"}, data_sram, exp);
    idle(1);
  endtask

  initial begin
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_data", data_sram, 32'h0);
    check("rst_valid", {31'd0, sram_datareadvalid}, 32'd0);
    check("rst_oob", {31'd0, oob_err}, 32'd0);
    check("rst_ovr", {31'd0, ovr_err}, 32'd0);
    n_rst = 1'b1;
    idle(1);

    wr_word(13'd0, 13'd5, 1'b0, 32'hA5A5_0001);
    idle(1);
    rd_expect("basic_read", 13'd0, 13'd5, 32'hA5A5_0001);

    wr_word(13'd0, 13'd7, 1'b0, 32'h1111_2222);
    wr_word(13'd1, 13'd7, 1'b1, 32'h00FF_00FF);
    rd_expect("out_region", 13'd1, 13'd7, 32'h00FF_00FF);
    rd_expect("rc_region", 13'd0, 13'd7, 32'h1111_2222);

    wr_word(13'd0, 13'd9, 1'b0, 32'hCAFE_0035);
    rd_expect("wr_then_rd", 13'd0, 13'd9, 32'hCAFE_0035);

    cyc(1'b1, 1'b0, 1'b0, 13'd0, 13'd5, 32'h0, 32'h0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 13'd0, 13'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    check("ovr_valid", {31'd0, sram_datareadvalid}, 32'd1);
    check("ovr_data", data_sram, 32'hA5A5_0001);
    check("ovr_set", {31'd0, ovr_err}, 32'd1);
    idle(1);
    check("ovr_single_pulse", {31'd0, sram_datareadvalid}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 13'd0, 13'd0, 32'h0, 32'h0, 1'b1);
    check("ovr_clear", {31'd0, ovr_err}, 32'd0);
    rd_expect("ovr_mem_kept", 13'd0, 13'd5, 32'hA5A5_0001);

    wr_word(13'd0, 13'd0, 1'b0, 32'h1234_5678);
    check("oob_clean", {31'd0, oob_err}, 32'd0);
    wr_word(13'd0, 13'd4096, 1'b0, 32'hBAD0_0001);
    check("oob_wr_flag", {31'd0, oob_err}, 32'd1);
    rd_expect("oob_region", 13'd2, 13'd0, 32'h0);
    rd_expect("oob_col", 13'd0, 13'd4096, 32'h0);
    rd_expect("oob_wr_dropped", 13'd0, 13'd0, 32'h1234_5678);
    cyc(1'b0, 1'b0, 1'b0, 13'd0, 13'd0, 32'h0, 32'h0, 1'b1);
    check("oob_clear", {31'd0, oob_err}, 32'd0);

    cyc(1'b1, 1'b0, 1'b0, 13'd0, 13'd5, 32'h0, 32'h0, 1'b0);
    n_rst = 1'b0;
    sram_en = 1'b0;
    @(posedge clk);
    #2;
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("rst_abort_novalid", {31'd0, sram_datareadvalid}, 32'd0);
    end
    rd_expect("rst_abort_idle", 13'd0, 13'd5, 32'hA5A5_0001);

    for (int i = 0; i < 3000; i++) begin
      logic [12:0] r_region;
      logic [12:0] r_col;
      logic        r_en;
      logic        r_wr;
      logic        r_sel;
      logic        r_clr;
      int          pick;
      pick     = $urandom_range(0, 9);
      r_region = (pick == 0) ? 13'($urandom_range(2, 8191)) : 13'($urandom_range(0, 1));
      pick     = $urandom_range(0, 9);
      if (pick == 0)      r_col = 13'($urandom_range(4096, 8191));
      else if (pick == 1) r_col = 13'd4095;
      else                r_col = 13'($urandom_range(0, 15));
      r_en  = 1'($urandom_range(0, 1));
      r_wr  = 1'($urandom_range(0, 1));
      r_sel = 1'($urandom_range(0, 1));
      r_clr = ($urandom_range(0, 15) == 0);
      if (r_en && !r_wr && !is_oob({r_region, r_col}) && !model_mem.exists(int'({r_region, r_col})))
        r_wr = 1'b1;
      n_rst = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      cyc(r_en, r_wr, r_sel, r_region, r_col, $urandom, $urandom, r_clr);
    end

    n_rst = 1'b1;
    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter ROW_WORDS, default 4096, meaning words per bank; legal column index range is 0..ROW_WORDS-1.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 n_rst  input  1  reset, asynchronous and active-low.
REQ-004 sram_en  input  1  request strobe, one request per high cycle.
REQ-005 mode_sram  input  1  request type: 1 = write, 0 = read.
REQ-006 addrCalc_mode_sram  input  1  write-data source select: 0 = sram_dataFromSDRAM (row-cache fill), 1 = postFilterData (output array).
REQ-007 address_sram  input  26  request address: [25:13] region, [12:0] column.
REQ-008 sram_dataFromSDRAM  input  32  delayed SDRAM pixel word.
REQ-009 postFilterData  input  32  filter result word.
REQ-010 clear_err  input  1  synchronous clear of the sticky error flags.
REQ-011 data_sram  output  32  read data.
REQ-012 sram_datareadvalid  output  1  one-cycle read-complete pulse.
REQ-013 oob_err  output  1  sticky flag: out-of-range address seen.
REQ-014 ovr_err  output  1  sticky flag: request dropped while busy.

Function
REQ-015 Storage SHALL be two banks of ROW_WORDS x 32: region 0 = row cache, region 1 = output array.
REQ-016 FSM states SHALL be IDLE, RD_MEM, RD_OUT.
REQ-017 IDLE: sram_en=1 with mode_sram=1 SHALL commit the write at that edge and stay in IDLE; back-to-back writes are accepted every cycle.
REQ-018 IDLE: sram_en=1 with mode_sram=0 SHALL register the address and go to RD_MEM.
REQ-019 RD_MEM SHALL read the bank synchronously and go to RD_OUT.
REQ-020 RD_OUT SHALL drive data_sram with the read word, assert sram_datareadvalid for exactly this cycle, and return to IDLE.
REQ-021 Read latency: request accepted at edge N -> valid high in cycle N+2; the next request is accepted at edge N+3 at the earliest.
REQ-022 data_sram SHALL hold its last read value until the next RD_OUT.
REQ-023 sram_en=1 in RD_MEM or RD_OUT SHALL be ignored (no write, no read) and SHALL set ovr_err.
REQ-024 A write SHALL store the source selected by addrCalc_mode_sram, sampled in the accept cycle.
REQ-025 A read issued the cycle after a write to the same address SHALL return the new data.
REQ-026 Out-of-range address (region > 1 or column >= ROW_WORDS): a write SHALL be dropped; a read SHALL complete with normal latency and return 32'h0; both SHALL set oob_err.
REQ-027 clear_err=1 SHALL clear both sticky flags; if an error event occurs in the same cycle, the set SHALL win.
REQ-028 Memory contents SHALL NOT be initialised by reset; a read of a never-written location returns X in simulation.

Reset
REQ-029 n_rst low SHALL force state=IDLE, data_sram=0, sram_datareadvalid=0, oob_err=0, ovr_err=0.
REQ-030 n_rst low mid-read SHALL abort the read; no valid pulse follows the release of reset.

Structure
REQ-031 Package sram_pkg SHALL hold ROW_WORDS default, region constants REGION_ROWCACHE=13'd0 and REGION_OUTPUT=13'd1, and the FSM state enum.
REQ-032 Sub-module sram_bank (single-port synchronous RAM: clk, we, addr, wdata, rdata) SHALL be instantiated twice, once per region.

Verification
REQ-033 Reset -> all outputs 0; read of {13'd0,13'd5} after a write of 32'hA5A5_0001 with addrCalc_mode_sram=0 -> valid 2 cycles later, data 32'hA5A5_0001.
REQ-034 Write postFilterData=32'h00FF_00FF to {13'd1,13'd7} with mode 1, then read the same address and {13'd0,13'd7} -> output region returns 32'h00FF_00FF; row-cache region does not.
REQ-035 Write at edge N, read of the same address at edge N+1 -> new data returned at cycle N+3.
REQ-036 Read accepted, sram_en pulsed in RD_MEM -> exactly one valid pulse, ovr_err=1, memory unchanged; clear_err -> ovr_err=0.
REQ-037 Read of {13'd2,13'd0} and of column 13'd4096 -> data 0 with valid; write to column 4096 is dropped; oob_err=1.
REQ-038 n_rst asserted in RD_MEM -> no sram_datareadvalid pulse after reset release; FSM in IDLE.
